// File: rtl/main_control_pkg.sv
// Shared control-code definitions for the ID-stage main decoder: opcodes, functs,
// control-word field encodings and bit positions.
package main_control_pkg;

  localparam int CTRL_W = 14;

  localparam int NPC_BIT = 13;
  localparam int JMP_MSB = 12;
  localparam int JMP_LSB = 11;
  localparam int RW_BIT  = 10;
  localparam int DST_MSB = 9;
  localparam int DST_LSB = 8;
  localparam int M2R_MSB = 7;
  localparam int M2R_LSB = 6;
  localparam int MW_BIT  = 5;
  localparam int SRC_MSB = 4;
  localparam int SRC_LSB = 3;
  localparam int ALU_MSB = 2;
  localparam int ALU_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic       NPC_SEQ  = 1'b0;
  localparam logic       NPC_JUMP = 1'b1;
  localparam logic [1:0] JMP_BRANCH = 2'b00;
  localparam logic [1:0] JMP_REG    = 2'b01;
  localparam logic [1:0] JMP_DIRECT = 2'b10;
  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_WORD = 2'b01;
  localparam logic [1:0] M2R_HALF = 2'b10;
  localparam logic [1:0] M2R_BYTE = 2'b11;
  localparam logic [1:0] SRC_BUSB  = 2'b00;
  localparam logic [1:0] SRC_SEXT  = 2'b01;
  localparam logic [1:0] SRC_ZEXT  = 2'b10;
  localparam logic [1:0] SRC_UPPER = 2'b11;
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_BR   = 3'b001;
  localparam logic [2:0] ALU_ANDI = 3'b010;
  localparam logic [2:0] ALU_ORI  = 3'b011;
  localparam logic [2:0] ALU_XORI = 3'b100;
  localparam logic [2:0] ALU_SLTI = 3'b101;
  localparam logic [2:0] ALU_R    = 3'b110;

  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic       npc,
    input logic [1:0] jmp,
    input logic       rw,
    input logic [1:0] dst,
    input logic [1:0] m2r,
    input logic       mw,
    input logic [1:0] src,
    input logic [2:0] alu
  );
    logic [CTRL_W-1:0] w;
    w                  = '0;
    w[NPC_BIT]         = npc;
    w[JMP_MSB:JMP_LSB] = jmp;
    w[RW_BIT]          = rw;
    w[DST_MSB:DST_LSB] = dst;
    w[M2R_MSB:M2R_LSB] = m2r;
    w[MW_BIT]          = mw;
    w[SRC_MSB:SRC_LSB] = src;
    w[ALU_MSB:ALU_LSB] = alu;
    return w;
  endfunction

endpackage

// File: rtl/main_control_decode.sv
// Combinational main decoder: opcode/funct/zero flag -> 14-bit control word.
// Optional MAIN_CONTROL_ILLEGAL_DET_EN adds an illegal-instruction flag.
module main_control_decode
  import main_control_pkg::*;
(
  input  logic              zero_i,
  input  logic [5:0]        op_i,
  input  logic [5:0]        funct_i,
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
  output logic              illegal_o,
`endif
  output logic [CTRL_W-1:0] ctrl_o
);

  logic illegal_s;

  // Decode table; anything unlisted falls through to an all-zero NOP.
  always_comb begin
    ctrl_o    = '0;
    illegal_s = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV:
            ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RD, M2R_ALU, 1'b0, SRC_BUSB, ALU_R);
          FN_JR, FN_JALR:
            ctrl_o = pack_ctrl(NPC_JUMP, JMP_REG, 1'b0, DST_RT, M2R_ALU, 1'b0, SRC_BUSB, ALU_R);
          default: illegal_s = 1'b1;
        endcase
      end
      OP_LW, OP_LWU: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_WORD, 1'b0, SRC_SEXT, ALU_ADD);
      OP_LH, OP_LHU: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_HALF, 1'b0, SRC_SEXT, ALU_ADD);
      OP_LB, OP_LBU: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_BYTE, 1'b0, SRC_SEXT, ALU_ADD);
      OP_SW, OP_SH, OP_SB:
        ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b0, DST_RT, M2R_ALU, 1'b1, SRC_SEXT, ALU_ADD);
      // Taken branch sets next_pc_src directly from the compare; jmp_ctrl stays "branch".
      OP_BEQ: ctrl_o = pack_ctrl(zero_i, JMP_BRANCH, 1'b0, DST_RT, M2R_ALU, 1'b0, SRC_BUSB, ALU_BR);
      OP_BNE: ctrl_o = pack_ctrl(~zero_i, JMP_BRANCH, 1'b0, DST_RT, M2R_ALU, 1'b0, SRC_BUSB, ALU_BR);
      OP_J:   ctrl_o = pack_ctrl(NPC_JUMP, JMP_DIRECT, 1'b0, DST_RT, M2R_ALU, 1'b0, SRC_BUSB, ALU_ADD);
      OP_JAL: ctrl_o = pack_ctrl(NPC_JUMP, JMP_DIRECT, 1'b1, DST_R31, M2R_ALU, 1'b0, SRC_BUSB, ALU_ADD);
      OP_ADDI: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_ALU, 1'b0, SRC_SEXT, ALU_ADD);
      OP_SLTI: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_ALU, 1'b0, SRC_SEXT, ALU_SLTI);
      OP_ANDI: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_ALU, 1'b0, SRC_ZEXT, ALU_ANDI);
      OP_ORI:  ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_ALU, 1'b0, SRC_ZEXT, ALU_ORI);
      OP_XORI: ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_ALU, 1'b0, SRC_ZEXT, ALU_XORI);
      OP_LUI:  ctrl_o = pack_ctrl(NPC_SEQ, JMP_BRANCH, 1'b1, DST_RT, M2R_ALU, 1'b0, SRC_UPPER, ALU_ADD);
      default: illegal_s = 1'b1;
    endcase
  end

`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
  assign illegal_o = illegal_s;
`else
  logic unused_s;
  assign unused_s = illegal_s;
`endif

endmodule

// File: rtl/main_control.sv
// ID-stage main control: registers the decoded control word (1-cycle latency).
// Optional MAIN_CONTROL_ILLEGAL_DET_EN adds registered o_illegal_instr.
module main_control
  import main_control_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bus_a_is_zero,
  input  logic [5:0]        i_op,
  input  logic [5:0]        i_funct,
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
  output logic              o_illegal_instr,
`endif
  output logic [CTRL_W-1:0] o_ctrl_regs
);

  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;

`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
  logic illegal_d;
  logic illegal_q;
`endif

  main_control_decode u_decode (
    .zero_i    (i_bus_a_is_zero),
    .op_i      (i_op),
    .funct_i   (i_funct),
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
    .illegal_o (illegal_d),
`endif
    .ctrl_o    (ctrl_d)
  );

  // Control word register; async reset clears it to a NOP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
  // Illegal flag register, aligned with the control word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign o_illegal_instr = illegal_q;
`endif

  assign o_ctrl_regs = ctrl_q;

endmodule

// File: tb/tb_main_control.sv
// Scoreboard bench for main_control: stimulus pushes hand-computed control words,
// a negedge monitor pops and compares. Honors MAIN_CONTROL_ILLEGAL_DET_EN.
module tb_main_control;

  typedef struct {
    logic [13:0] ctrl;
    logic        ill;
    string       name;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_bus_a_is_zero;
  logic [5:0]  i_op;
  logic [5:0]  i_funct;
  logic [13:0] o_ctrl_regs;
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
  logic        o_illegal_instr;
`endif

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  main_control dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_bus_a_is_zero (i_bus_a_is_zero),
    .i_op            (i_op),
    .i_funct         (i_funct),
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
    .o_illegal_instr (o_illegal_instr),
`endif
    .o_ctrl_regs     (o_ctrl_regs)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: one registered result per queued expectation, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (o_ctrl_regs !== e.ctrl) begin
        n_err = n_err + 1;
        $display("FAIL %s: ctrl got %h expected %h", e.name, o_ctrl_regs, e.ctrl);
      end
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
      n_cmp = n_cmp + 1;
      if (o_illegal_instr !== e.ill) begin
        n_err = n_err + 1;
        $display("FAIL %s_illegal: got %b expected %b", e.name, o_illegal_instr, e.ill);
      end
`endif
    end
  end

  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic [13:0] exp, input logic ill, input string nm);
    exp_t e;
    @(negedge i_clk);
    i_op = op;
    i_funct = fn;
    i_bus_a_is_zero = z;
    @(posedge i_clk);
    #1;
    e.ctrl = exp;
    e.ill  = ill;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge i_clk);
      budget = budget - 1;
    end
    if (exp_q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string nm);
    n_cmp = n_cmp + 1;
    if (o_ctrl_regs !== 14'h0000) begin
      n_err = n_err + 1;
      $display("FAIL %s: ctrl got %h expected 0000", nm, o_ctrl_regs);
    end
`ifdef MAIN_CONTROL_ILLEGAL_DET_EN
    n_cmp = n_cmp + 1;
    if (o_illegal_instr !== 1'b0) begin
      n_err = n_err + 1;
      $display("FAIL %s_illegal: got %b expected 0", nm, o_illegal_instr);
    end
`endif
  endtask

  logic [5:0] alu_fn [15];
  logic [5:0] ld_op  [6];
  logic [13:0] ld_exp [6];
  logic [5:0] st_op  [3];
  logic [5:0] im_op  [6];
  logic [13:0] im_exp [6];

  initial begin
    n_cmp = 0;
    n_err = 0;
    alu_fn = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
               6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b000000,
               6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111};
    ld_op  = '{6'b100011, 6'b100111, 6'b100001, 6'b100101, 6'b100000, 6'b100100};
    ld_exp = '{14'h0448, 14'h0448, 14'h0488, 14'h0488, 14'h04C8, 14'h04C8};
    st_op  = '{6'b101011, 6'b101001, 6'b101000};
    im_op  = '{6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111};
    im_exp = '{14'h0408, 14'h040D, 14'h0412, 14'h0413, 14'h0414, 14'h0418};

    i_rst_n = 1'b0;
    i_op = 6'b100011;
    i_funct = 6'b000000;
    i_bus_a_is_zero = 1'b0;
    #3;
    check_reset("reset_hold");
    @(posedge i_clk);
    #1;
    check_reset("reset_hold_edge");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    apply(6'b100011, 6'b000000, 1'b0, 14'h0448, 1'b0, "lw_after_reset");
    drain();
    // Asynchronous reset asserted mid-cycle, away from any rising edge.
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    #1;
    i_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(6'b000000, alu_fn[i], 1'b0, 14'h0506, 1'b0, $sformatf("rtype_fn%0d", i));
    end
    apply(6'b000000, 6'b001000, 1'b1, 14'h2806, 1'b0, "jr");
    apply(6'b000000, 6'b001001, 1'b0, 14'h2806, 1'b0, "jalr");

    apply(6'b000100, 6'b000000, 1'b0, 14'h0001, 1'b0, "beq_nt");
    apply(6'b000100, 6'b111111, 1'b1, 14'h2001, 1'b0, "beq_t");
    apply(6'b000101, 6'b000000, 1'b1, 14'h0001, 1'b0, "bne_nt");
    apply(6'b000101, 6'b000000, 1'b0, 14'h2001, 1'b0, "bne_t");

    apply(6'b000010, 6'b100000, 1'b1, 14'h3000, 1'b0, "j");
    apply(6'b000011, 6'b000000, 1'b0, 14'h3600, 1'b0, "jal");

    for (int i = 0; i < 6; i++) begin
      apply(ld_op[i], 6'b001000, 1'b1, ld_exp[i], 1'b0, $sformatf("load%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      apply(st_op[i], 6'b000000, 1'b0, 14'h0028, 1'b0, $sformatf("store%0d", i));
    end
    for (int i = 0; i < 6; i++) begin
      apply(im_op[i], 6'b100000, 1'b0, im_exp[i], 1'b0, $sformatf("imm%0d", i));
    end

    apply(6'b111111, 6'b000000, 1'b0, 14'h0000, 1'b1, "illegal_op");
    apply(6'b001000, 6'b000000, 1'b0, 14'h0408, 1'b0, "legal_after_op");
    apply(6'b000000, 6'b111111, 1'b0, 14'h0000, 1'b1, "illegal_funct");
    apply(6'b000000, 6'b100000, 1'b0, 14'h0506, 1'b0, "legal_after_funct");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
